fp_add_share_arbiter: RTL

- Shares one pipelined double-precision adder (`double_adder_pipe`) among NUM_REQ independent requesters, such as per-cell Pair-HMM recurrence units.
- Round-robin arbitration; each requester has an outstanding-operation credit limit.
- Encodes requester id and sequence number into the adder tag, and routes each `tag_out` result back to its owner.
- Sits between the requester units and the single adder instance.

---
 rtl/fp_share_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_add_share_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fp_share_pkg.sv
// Shared defaults and tag layout for arbiters that front a single pipelined FP unit.
// The tag carries the owning requester id in its upper bits and a per-requester sequence number below.
package fp_share_pkg;

  localparam int FP_W        = 64;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);
  localparam int SEQ_W_DEF   = 2;
  localparam int TAG_W_DEF   = ID_W_DEF + SEQ_W_DEF;
  localparam int MAX_OUT_DEF = 4;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [SEQ_W_DEF-1:0] seq;
  } share_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester at or after ptr.
// The caller owns the pointer register and loads ptr_next each cycle.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_id,
  output logic [PTR_W-1:0] ptr_next
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
    ptr_next = ptr;
    if (advance && found) begin
      ptr_next = PTR_W'((int'(grant_id) + 1) % N);
    end
  end

endmodule

// File: rtl/fp_add_share_arbiter.sv
// Shares one pipelined double adder among NUM_REQ requesters with per-requester credits,
// tag-based result routing back to the owner, and a sticky protocol-error flag.
module fp_add_share_arbiter
  import fp_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int SEQ_W   = SEQ_W_DEF,
  parameter int TAG_W   = ID_W + SEQ_W,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][FP_W-1:0]   req_a,
  input  logic [NUM_REQ-1:0][FP_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [FP_W-1:0]                resp_z,
  output logic [FP_W-1:0]                add_a,
  output logic [FP_W-1:0]                add_b,
  output logic                           add_valid,
  output logic [TAG_W-1:0]               add_tag,
  input  logic                           add_stall,
  input  logic                           add_done,
  input  logic [FP_W-1:0]                add_z,
  input  logic [TAG_W-1:0]               add_tag_out,
  output logic                           err
);

  // Counter must reach MAX_OUT, which may equal 2^SEQ_W.
  localparam int CNT_W = SEQ_W + 1;

  logic                           can_load;
  logic                           advance;
  logic [NUM_REQ-1:0]             eligible;
  logic [NUM_REQ-1:0]             grant;
  logic [ID_W-1:0]                grant_id;
  logic [ID_W-1:0]                rr_ptr;
  logic [ID_W-1:0]                rr_next;
  logic [NUM_REQ-1:0][CNT_W-1:0]  out_cnt;
  logic [NUM_REQ-1:0][SEQ_W-1:0]  seq_cnt;
  logic [NUM_REQ-1:0][SEQ_W-1:0]  rseq;
  logic [ID_W-1:0]                done_id;
  logic [SEQ_W-1:0]               done_seq;
  logic                           done_owned;

  assign can_load = !add_valid || !add_stall;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id),
    .ptr_next (rr_next)
  );

  assign advance   = can_load && (|grant);
  assign req_ready = can_load ? grant : '0;

  assign done_id    = add_tag_out[TAG_W-1:SEQ_W];
  assign done_seq   = add_tag_out[SEQ_W-1:0];
  assign done_owned = add_done && (out_cnt[done_id] != '0);

  // Issue stage: the single register facing the adder, frozen while it stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      add_valid <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_tag   <= '0;
      rr_ptr    <= '0;
      seq_cnt   <= '0;
    end else if (advance) begin
      add_valid         <= 1'b1;
      add_a             <= req_a[grant_id];
      add_b             <= req_b[grant_id];
      add_tag           <= {grant_id, seq_cnt[grant_id]};
      seq_cnt[grant_id] <= seq_cnt[grant_id] + 1'b1;
      rr_ptr            <= rr_next;
    end else if (can_load) begin
      add_valid <= 1'b0;
    end
  end

  // Response stage: one-cycle routing of adder results back to their owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= '0;
      resp_z     <= '0;
      rseq       <= '0;
      out_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (add_done) begin
        rseq[done_id] <= rseq[done_id] + 1'b1;
        if (!done_owned || (done_seq != rseq[done_id])) begin
          err <= 1'b1;
        end
        if (done_owned) begin
          resp_valid[done_id] <= 1'b1;
          resp_z              <= add_z;
        end
      end
      // Accept and return on the same edge for one requester cancel out.
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt[i] <= out_cnt[i]
                      + CNT_W'(advance && grant[i])
                      - CNT_W'(done_owned && (done_id == ID_W'(i)));
      end
    end
  end

endmodule
